axi_forwarding_cam_v2: RTL and testbench
========================================

Name: axi_forwarding_cam_v2

Overview:
Parametrised next-generation SID forwarding lookup for the AXI crossbar. It monitors the head of an input FIFO and extracts the destination field of each packet's SID. A block-RAM CAM lookup then raises a one-hot forward request toward the crossbar outputs. Over the previous generation it adds:
- configurable field width and SID bit position;
- per-entry valid bits with a default route for misses and out-of-range ports;
- exactly one lookup per packet;
- saturating statistics with lossless clear-on-read and a miss counter.

Parameters:
BASE, 0, setting-bus base address; aligned to 2^(FIELD_W+1).
WIDTH, 64, FIFO word width.
NUM_OUTPUTS, 4, crossbar output count (2..256). PORT_W = max(1, clog2(NUM_OUTPUTS)).
FIELD_W, 8, width of network and host fields (4..8).
DST_LSB, 0, bit index of the DST host field LSB in the header word; network field sits directly above it. Requires DST_LSB+2*FIELD_W <= WIDTH.
DEFAULT_PORT, 0, output used on a miss; must be < NUM_OUTPUTS.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous soft clear; same effect as reset except CAM contents are retained
o_tdata  in  WIDTH  monitored FIFO output data
o_tvalid  in  1  monitored FIFO valid
o_tready  in  1  monitored FIFO ready
o_tlast  in  1  monitored FIFO last
pkt_present  in  1  a complete packet is present in the FIFO
local_addr  in  FIELD_W  this crossbar's network address
set_stb  in  1  setting-bus strobe
set_addr  in  16  setting-bus address
set_data  in  32  setting-bus data
forward_valid  out  NUM_OUTPUTS  one-hot forward request
forward_ack  in  NUM_OUTPUTS  per-output acknowledge; held high for the duration of the packet transfer
rb_rd_stb  in  1  readback strobe
rb_addr  in  PORT_W+1  readback select
rb_data  out  32  readback data (combinational from rb_addr)

Behaviour:
- Packet monitor, states WAIT_SOF/WAIT_EOF:
  - WAIT_SOF->WAIT_EOF on o_tvalid&o_tready.
  - WAIT_EOF->WAIT_SOF on o_tvalid&o_tready&o_tlast.
  - A single-beat packet (tlast on the SOF beat) remains in WAIT_SOF.
- Capture:
  - In WAIT_SOF with o_tvalid&pkt_present and the armed flag set: register dst and clear armed.
  - Armed is set on reset/clear and on every SOF handshake. Result: exactly one lookup per packet, even if the header stalls.
- Address formation:
  - local = (net field == local_addr).
  - CAM address = {local, local ? host : net}.
  - Depth 2^(FIELD_W+1): lower half network entries, upper half host entries.
- CAM entry = {valid, port[PORT_W-1:0]}, synchronous read, read-first.
  - A write to the address being read in the same cycle returns the old entry.
- Pipeline:
  - header beat at cycle t → dst registered at t+1 → CAM read registered at t+2 → forward_valid asserted at t+3.
  - On a miss (valid=0 or port >= NUM_OUTPUTS) forward_valid = 1<<DEFAULT_PORT and the miss counter increments.
- Demux FSM:
  - IDLE→LOOKUP on capture.
  - LOOKUP→FORWARD when the CAM read is available; sets forward_valid.
  - FORWARD→WAIT when (forward_ack & forward_valid) != 0; clears forward_valid.
  - WAIT→IDLE when forward_ack == 0.
  - Captures are accepted only in IDLE. Monitor and armed logic run independently.
- Setting bus:
  - Write when set_stb & (set_addr[15:FIELD_W+1] == BASE>>(FIELD_W+1)).
  - mem[set_addr[FIELD_W:0]] <= {set_data[31], set_data[PORT_W-1:0]}.
- Initial CAM contents:
  - Host entry h is valid with port h>>4 if (h>>4) < NUM_OUTPUTS; otherwise invalid.
  - All network entries are invalid.
  - Reset and clear do not alter the CAM.
- Statistics: 32-bit counters, per output m < NUM_OUTPUTS, plus a miss counter at rb_addr == NUM_OUTPUTS.
  - Output counter m increments on forward_ack[m] & forward_valid[m].
  - Counters saturate at 0xFFFFFFFF.
  - rb_rd_stb with a legal rb_addr sets a clear-pending flag. The next cycle loads the counter with 0, or with 1 if an increment occurs in that cycle (no event lost).
  - rb_addr > NUM_OUTPUTS reads 0 and has no effect.
- Reset/clear:
  - forward_valid=0, demux IDLE, monitor WAIT_SOF, armed=1, counters and pending flags 0.
  - Mid-packet reset drops the pending request.

Test Plan:
- NUM_OUTPUTS=4, local_addr=0x02, header DST=0x0231 → forward_valid=4'b1000 at header cycle+3; ack → 0; ack drop → accepts next packet.
- Write addr BASE+0x005 data 0x80000002, header DST=0x0577 → forward_valid=4'b0100. Header DST=0x0677 (invalid entry) → 1<<DEFAULT_PORT, miss counter reads 1.
- Header held valid with o_tready=0 for 20 cycles → exactly one forward_valid assertion, statistics +1 only.
- Two 1-beat packets back to back, each acked → counter[3] reads 2. rb_rd_stb on rb_addr=3, increment on the following cycle → next read returns 1.
- Force counter to 0xFFFFFFFF, ack again → stays 0xFFFFFFFF. rb_addr=7 → rb_data=0.
- Assert clear while in FORWARD → forward_valid=0 next cycle, written CAM entries preserved on the next lookup.

Source files
------------

// File: rtl/axi_forwarding_cam_v2.sv
// SID forwarding lookup: watches the FIFO head, looks the DST field up in a block-RAM CAM
// and raises a one-hot forward request; keeps saturating per-output and miss statistics.
module axi_forwarding_cam_v2 #(
  parameter int BASE         = 0,
  parameter int WIDTH        = 64,
  parameter int NUM_OUTPUTS  = 4,
  parameter int FIELD_W      = 8,
  parameter int DST_LSB      = 0,
  parameter int DEFAULT_PORT = 0,
  localparam int PORT_W      = (NUM_OUTPUTS > 2) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       o_tdata,
  input  logic                   o_tvalid,
  input  logic                   o_tready,
  input  logic                   o_tlast,
  input  logic                   pkt_present,
  input  logic [FIELD_W-1:0]     local_addr,
  input  logic                   set_stb,
  input  logic [15:0]            set_addr,
  input  logic [31:0]            set_data,
  output logic [NUM_OUTPUTS-1:0] forward_valid,
  input  logic [NUM_OUTPUTS-1:0] forward_ack,
  input  logic                   rb_rd_stb,
  input  logic [PORT_W:0]        rb_addr,
  output logic [31:0]            rb_data
);

  localparam int CAM_AW = FIELD_W + 1;
  localparam int DEPTH  = 1 << CAM_AW;
  localparam int ENT_W  = PORT_W + 1;
  localparam int NCNT   = NUM_OUTPUTS + 1;

  typedef enum logic {MON_WAIT_SOF, MON_WAIT_EOF} mon_state_t;
  typedef enum logic [1:0] {DMX_IDLE, DMX_LOOKUP, DMX_FORWARD, DMX_WAIT} dmx_state_t;

  // Power-up table: host entry h routes to h>>4 when that port exists.
  function automatic logic [ENT_W-1:0] default_entry(input logic [CAM_AW-1:0] addr);
    int p;
    p = int'(addr[FIELD_W-1:0]) >> 4;
    if (addr[FIELD_W] && (p < NUM_OUTPUTS))
      return {1'b1, PORT_W'(p)};
    return '0;
  endfunction

  logic w_rst;
  assign w_rst = reset | clear;

  // Packet monitor and one-shot header capture
  mon_state_t r_mon_state, w_mon_next;
  dmx_state_t r_dmx_state, w_dmx_next;
  logic       r_armed;
  logic       w_beat, w_sof, w_capture;
  logic [2*FIELD_W-1:0] r_dst;

  assign w_beat    = o_tvalid & o_tready;
  assign w_sof     = (r_mon_state == MON_WAIT_SOF) & w_beat;
  assign w_capture = (r_mon_state == MON_WAIT_SOF) & o_tvalid & pkt_present & r_armed &
                     (r_dmx_state == DMX_IDLE);

  always_comb begin
    w_mon_next = r_mon_state;
    case (r_mon_state)
      MON_WAIT_SOF: if (w_beat && !o_tlast) w_mon_next = MON_WAIT_EOF;
      MON_WAIT_EOF: if (w_beat && o_tlast) w_mon_next = MON_WAIT_SOF;
      default:      w_mon_next = MON_WAIT_SOF;
    endcase
  end

  // Re-arming on the SOF handshake wins so a capture on that same beat still arms the next packet.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_mon_state <= MON_WAIT_SOF;
      r_armed     <= 1'b1;
    end else begin
      r_mon_state <= w_mon_next;
      if (w_sof)
        r_armed <= 1'b1;
      else if (w_capture)
        r_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture)
      r_dst <= o_tdata[DST_LSB +: 2*FIELD_W];
  end

  // CAM address and setting-bus write
  logic [FIELD_W-1:0] w_net, w_host;
  logic               w_local;
  logic [CAM_AW-1:0]  w_rd_addr, w_wr_addr;
  logic               w_set_hit;
  logic [ENT_W-1:0]   w_wr_entry;

  assign w_host     = r_dst[FIELD_W-1:0];
  assign w_net      = r_dst[2*FIELD_W-1:FIELD_W];
  assign w_local    = (w_net == local_addr);
  assign w_rd_addr  = {w_local, w_local ? w_host : w_net};
  assign w_set_hit  = set_stb && (set_addr[15:CAM_AW] == (16-CAM_AW)'(BASE >> CAM_AW));
  assign w_wr_addr  = set_addr[CAM_AW-1:0];
  assign w_wr_entry = {set_data[31], set_data[PORT_W-1:0]};

  // RAM holds each entry XORed with its power-up value, so zeroed block RAM
  // reads back as the default table without a separate init pass.
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ENT_W-1:0]  r_rd_raw;
  logic [CAM_AW-1:0] r_rd_addr;
  logic [ENT_W-1:0]  w_rd_entry;

  always_ff @(posedge clk) begin
    r_rd_raw  <= r_mem[w_rd_addr];
    r_rd_addr <= w_rd_addr;
    if (w_set_hit)
      r_mem[w_wr_addr] <= w_wr_entry ^ default_entry(w_wr_addr);
  end

  assign w_rd_entry = r_rd_raw ^ default_entry(r_rd_addr);

  logic [PORT_W-1:0]      w_rd_port;
  logic                   w_miss;
  logic [NUM_OUTPUTS-1:0] w_fwd_onehot;

  assign w_rd_port = w_rd_entry[PORT_W-1:0];
  assign w_miss    = !w_rd_entry[PORT_W] ||
                     ({{(32-PORT_W){1'b0}}, w_rd_port} >= 32'(NUM_OUTPUTS));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_onehot
      assign w_fwd_onehot[gi] = w_miss ? (gi == DEFAULT_PORT) : (w_rd_port == PORT_W'(gi));
    end
  endgenerate

  // Demux FSM
  logic [NUM_OUTPUTS-1:0] r_fwd, w_fwd_next;
  logic                   r_rd_valid;
  logic                   w_miss_evt;

  always_comb begin
    w_dmx_next = r_dmx_state;
    w_fwd_next = r_fwd;
    w_miss_evt = 1'b0;
    case (r_dmx_state)
      DMX_IDLE:   if (w_capture) w_dmx_next = DMX_LOOKUP;
      DMX_LOOKUP: if (r_rd_valid) begin
        w_dmx_next = DMX_FORWARD;
        w_fwd_next = w_fwd_onehot;
        w_miss_evt = w_miss;
      end
      DMX_FORWARD: if ((forward_ack & r_fwd) != '0) begin
        w_dmx_next = DMX_WAIT;
        w_fwd_next = '0;
      end
      DMX_WAIT:   if (forward_ack == '0) w_dmx_next = DMX_IDLE;
      default:    w_dmx_next = DMX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_dmx_state <= DMX_IDLE;
      r_fwd       <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_dmx_state <= w_dmx_next;
      r_fwd       <= w_fwd_next;
      r_rd_valid  <= (r_dmx_state == DMX_LOOKUP) && !r_rd_valid;
    end
  end

  assign forward_valid = r_fwd;

  // Statistics: index NUM_OUTPUTS is the miss counter
  logic [31:0] w_cnt_rb [NCNT];

  generate
    for (gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic        r_cnt_reg_unused_guard;
      logic [31:0] r_cnt;
      logic        r_clr_pend;
      logic        w_inc;
      wire  [31:0] w_cnt_next;

      if (gi < NUM_OUTPUTS) begin : g_out
        assign w_inc = forward_ack[gi] & r_fwd[gi];
      end else begin : g_miss
        assign w_inc = w_miss_evt;
      end

      // A pending clear restarts from the event in the same cycle so none is lost.
      assign w_cnt_next = r_clr_pend ? {31'd0, w_inc} :
                          (w_inc && (r_cnt != 32'hFFFF_FFFF)) ? r_cnt + 32'd1 : r_cnt;

      always_ff @(posedge clk) begin
        if (w_rst) begin
          r_cnt      <= '0;
          r_clr_pend <= 1'b0;
        end else begin
          r_cnt      <= w_cnt_next;
          r_clr_pend <= rb_rd_stb && (rb_addr == (PORT_W+1)'(gi));
        end
      end

      assign r_cnt_reg_unused_guard = 1'b0;
      assign w_cnt_rb[gi] = r_cnt;
    end
  endgenerate

  always_comb begin
    rb_data = '0;
    for (int i = 0; i < NCNT; i++)
      if (rb_addr == (PORT_W+1)'(i))
        rb_data = w_cnt_rb[i];
  end

  logic w_unused;
  assign w_unused = ^{o_tdata, set_data};

endmodule

// File: tb/tb_axi_forwarding_cam_v2.sv
// Scoreboard bench for axi_forwarding_cam_v2: expected forward requests are queued when a
// header is driven and compared when the DUT raises forward_valid; counters checked via readback.
`timescale 1ns/1ps
module tb_axi_forwarding_cam_v2;
  localparam int WIDTH        = 64;
  localparam int NUM_OUTPUTS  = 4;
  localparam int FIELD_W      = 8;
  localparam int PORT_W       = 2;
  localparam int DEFAULT_PORT = 0;

  logic                   clk = 1'b0;
  logic                   reset, clear;
  logic [WIDTH-1:0]       o_tdata;
  logic                   o_tvalid, o_tready, o_tlast, pkt_present;
  logic [FIELD_W-1:0]     local_addr;
  logic                   set_stb;
  logic [15:0]            set_addr;
  logic [31:0]            set_data;
  logic [NUM_OUTPUTS-1:0] forward_valid, forward_ack;
  logic                   rb_rd_stb;
  logic [PORT_W:0]        rb_addr;
  logic [31:0]            rb_data;

  always #5 clk = ~clk;

  axi_forwarding_cam_v2 #(
    .BASE(0), .WIDTH(WIDTH), .NUM_OUTPUTS(NUM_OUTPUTS), .FIELD_W(FIELD_W),
    .DST_LSB(0), .DEFAULT_PORT(DEFAULT_PORT)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
    .pkt_present(pkt_present), .local_addr(local_addr),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .forward_valid(forward_valid), .forward_ack(forward_ack),
    .rb_rd_stb(rb_rd_stb), .rb_addr(rb_addr), .rb_data(rb_data)
  );

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  exp_q [$];
  logic [31:0] exp_cnt [5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_inc(input int m);
    if (exp_cnt[m] != 32'hFFFF_FFFF)
      exp_cnt[m] = exp_cnt[m] + 32'd1;
  endtask

  task automatic check_cnt(input int m, input string tag);
    rb_addr = (PORT_W+1)'(m);
    #1;
    chk(tag, rb_data, exp_cnt[m]);
  endtask

  task automatic set_write(input logic [15:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb  = 1'b0;
  endtask

  // Present a header with tready low and wait for the request.
  task automatic start_pkt(input string tag, input logic [15:0] dst, input int nbeats,
                           input logic [3:0] exp_fwd, input bit miss);
    int         n;
    logic [3:0] expv;
    exp_q.push_back(exp_fwd);
    if (miss) model_inc(4);
    o_tdata     = 64'(dst);
    o_tvalid    = 1'b1;
    pkt_present = 1'b1;
    o_tready    = 1'b0;
    o_tlast     = (nbeats == 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (forward_valid == '0 && n < 20);
    expv = exp_q.pop_front();
    chk({tag, "_fwd"}, 32'(forward_valid), 32'(expv));
    chk({tag, "_lat"}, 32'(n), 32'd3);
    $display("pkt %s dst=0x%04h fwd=%b lat=%0d", tag, dst, forward_valid, n);
  endtask

  // Ack the request and stream the packet out, then release ack.
  task automatic finish_pkt(input string tag, input int nbeats);
    logic [3:0] f;
    f           = forward_valid;
    forward_ack = f;
    o_tready    = 1'b1;
    tick();
    chk({tag, "_ackdrop"}, 32'(forward_valid), 32'd0);
    for (int m = 0; m < NUM_OUTPUTS; m++)
      if (f[m]) model_inc(m);
    for (int b = 1; b < nbeats; b++) begin
      o_tdata = 64'(b);
      o_tlast = (b == nbeats - 1);
      tick();
    end
    o_tvalid    = 1'b0;
    o_tready    = 1'b0;
    o_tlast     = 1'b0;
    pkt_present = 1'b0;
    forward_ack = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    bit prev;
    logic [3:0] expv;

    reset = 1'b1; clear = 1'b0;
    o_tdata = '0; o_tvalid = 1'b0; o_tready = 1'b0; o_tlast = 1'b0; pkt_present = 1'b0;
    local_addr = 8'h02;
    set_stb = 1'b0; set_addr = '0; set_data = '0;
    forward_ack = '0; rb_rd_stb = 1'b0; rb_addr = '0;
    for (int m = 0; m < 5; m++) exp_cnt[m] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("reset_fwd", 32'(forward_valid), 32'd0);
    for (int m = 0; m < 5; m++) check_cnt(m, $sformatf("reset_cnt%0d", m));

    // Local host lookups from the power-up table
    start_pkt("local_a", 16'h0231, 1, 4'b1000, 0);
    finish_pkt("local_a", 1);
    start_pkt("local_b", 16'h0231, 1, 4'b1000, 0);
    finish_pkt("local_b", 1);
    check_cnt(3, "cnt3_two_pkts");
    start_pkt("multi", 16'h0215, 3, 4'b0010, 0);
    finish_pkt("multi", 3);
    check_cnt(1, "cnt1_multi");

    // Header stalled: must produce exactly one request
    exp_q.push_back(4'b1000);
    o_tdata = 64'(16'h0231); o_tvalid = 1'b1; pkt_present = 1'b1; o_tready = 1'b0; o_tlast = 1'b1;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (forward_valid != '0 && !prev) begin
        rises++;
        if (rises == 1) begin
          expv = exp_q.pop_front();
          chk("stall_fwd", 32'(forward_valid), 32'(expv));
        end
      end
      prev = (forward_valid != '0);
      forward_ack = forward_valid;
    end
    model_inc(3);
    chk("stall_rises", 32'(rises), 32'd1);
    $display("pkt stall dst=0x0231 rises=%0d", rises);
    o_tready = 1'b1; forward_ack = '0;
    tick();
    o_tvalid = 1'b0; o_tready = 1'b0; pkt_present = 1'b0; o_tlast = 1'b0;
    tick();
    chk("stall_after", 32'(forward_valid), 32'd0);
    check_cnt(3, "cnt3_stall");

    // Clear-on-read with an increment in the clearing cycle
    start_pkt("pend", 16'h0231, 1, 4'b1000, 0);
    check_cnt(3, "cnt3_before_rd");
    rb_rd_stb = 1'b1;
    tick();
    rb_rd_stb = 1'b0;
    finish_pkt("pend", 1);
    exp_cnt[3] = 32'd1;
    check_cnt(3, "cnt3_after_rd");

    // Saturation
    force dut.g_cnt[3].w_cnt_next = 32'hFFFF_FFFF;
    tick();
    release dut.g_cnt[3].w_cnt_next;
    exp_cnt[3] = 32'hFFFF_FFFF;
    check_cnt(3, "cnt3_forced");
    start_pkt("sat", 16'h0231, 1, 4'b1000, 0);
    finish_pkt("sat", 1);
    check_cnt(3, "cnt3_saturated");

    // Setting-bus writes (0x0206 lies outside the block's window)
    set_write(16'h0005, 32'h8000_0002);
    set_write(16'h0206, 32'h8000_0003);
    set_write(16'h013F, 32'h8000_0001);
    set_write(16'h0131, 32'h0000_0001);
    start_pkt("net5", 16'h0577, 1, 4'b0100, 0);
    finish_pkt("net5", 1);
    start_pkt("net6_miss", 16'h0677, 1, 4'b0001, 1);
    finish_pkt("net6_miss", 1);
    check_cnt(4, "miss_cnt_1");
    start_pkt("host50_miss", 16'h0250, 1, 4'b0001, 1);
    finish_pkt("host50_miss", 1);
    start_pkt("host3f_wr", 16'h023F, 1, 4'b0010, 0);
    finish_pkt("host3f_wr", 1);
    start_pkt("host31_inv", 16'h0231, 1, 4'b0001, 1);
    finish_pkt("host31_inv", 1);
    check_cnt(4, "miss_cnt_3");
    check_cnt(0, "cnt0_defaults");

    // Plain clear-on-read
    rb_addr = 3'd4;
    rb_rd_stb = 1'b1;
    tick();
    rb_rd_stb = 1'b0;
    tick();
    exp_cnt[4] = '0;
    check_cnt(4, "miss_cnt_cleared");

    // Soft clear while forwarding
    start_pkt("pre_clear", 16'h0577, 1, 4'b0100, 0);
    clear = 1'b1; o_tvalid = 1'b0; pkt_present = 1'b0;
    tick();
    clear = 1'b0;
    chk("clear_fwd", 32'(forward_valid), 32'd0);
    for (int m = 0; m < 5; m++) exp_cnt[m] = '0;
    check_cnt(3, "cnt3_after_clear");
    start_pkt("post_clear", 16'h0577, 1, 4'b0100, 0);
    finish_pkt("post_clear", 1);
    check_cnt(2, "cnt2_post_clear");

    // Out-of-range readback
    rb_addr = 3'd7;
    #1;
    chk("rb_addr7", rb_data, 32'd0);
    rb_addr = 3'd5;
    #1;
    chk("rb_addr5", rb_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
